rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
//  Parametrised successor time-of-day core for the VGA/bluetooth clock. Generates a 1 Hz tick
//  from CLK_100M as a single-cycle enable, not a derived clock, and counts hh:mm:ss in 24 h.
//  Provides a manual-set FSM driven by debounced button edges and a 12/24 h display mode.
//  Outputs are BCD digits for the VGA digit renderer and bluetooth status path.
// PARAMETERS
//  CLK_HZ        100_000_000  CLK_100M cycles per second (prescaler terminal count + 1)
//  DEBOUNCE_CYC  1_000_000    cycles a synchronised button must stay stable before accepted
// PORTS
//  CLK_100M     in   1  system clock
//  rst          in   1  reset, asynchronous, active-high
//  ena          in   1  1 = timekeeping runs; 0 = prescaler and time frozen (time NOT cleared)
//  set_mode     in   1  level: 1 = manual set, 0 = run (synchronised internally)
//  sel_btn      in   1  raw button: advance edited field
//  inc_btn      in   1  raw button: increment edited field
//  mode12       in   1  1 = 12 h display, 0 = 24 h display (display only)
//  hour_high    out  2  hour tens BCD
//  hour_low     out  4  hour units BCD
//  minute_high  out  3  minute tens BCD;  minute_low out 4 minute units BCD
//  second_high  out  3  second tens BCD;  second_low out 4 second units BCD
//  pm           out  1  1 when internal hour >= 12 (valid in both modes)
//  tick_1hz     out  1  one-cycle pulse per elapsed second (run state only)
// BEHAVIOUR
//  Reset: hour/min/sec=0, edit regs=0, state RUN, prescaler=0, tick_1hz=0, pm=0;
//   digits 00:00:00 (mode12=1: hour shows 12). rst mid-set -> RUN at 00:00:00 immediately.
//  Inputs: set_mode, sel_btn, inc_btn use 2-flop sync; buttons also debounced with a
//   DEBOUNCE_CYC stability counter. Accepted rising edge = 1-cycle pulse, 3 cycles + debounce
//   after the raw edge. Holding a button yields exactly one pulse.
//  Prescaler: 0..CLK_HZ-1; tick when ==CLK_HZ-1 && ena && state==RUN; held while ena=0.
//  Run: on tick sec++; 59->0 carries min++; 59->0 carries hour++; 23->0. Full carry
//   23:59:59 -> 00:00:00 in one cycle.
//  FSM (2-bit): RUN, SET_H, SET_M, SET_S.
//   RUN->SET_H on synced set_mode rise: edit regs <= current time, prescaler cleared, tick
//    in that same cycle discarded.
//   sel pulse: SET_H->SET_M->SET_S->SET_H. inc pulse: selected edit field +1, wrap 23/59/59.
//   sel+inc same cycle: inc applies to the field selected before the sel advance.
//   Any SET_x -> RUN on set_mode fall: time <= edit regs, prescaler=0, first tick CLK_HZ later.
//   Button pulses in RUN are ignored. ena does not gate the set FSM.
//  Display: combinational from regs, 0-cycle latency. Source is edit regs in SET_x, time in RUN.
//   mode12=1: h=0 -> 12; 13..23 -> h-12; 1..12 unchanged. BCD via /10 %10 on 5/6-bit values.
//   Internal count is always 24 h; mode12 toggling never changes state.
// CONFIGURATION
//  RTC_ALARM_EN defined: FSM adds SET_AH, SET_AM after SET_S (sel wraps SET_AM->SET_H).
//   Alarm regs reset 00:00. Added ports: alarm_on in 1; alarm_ring out 1, reset 0.
//   In SET_AH/SET_AM the display shows alarm hh:mm:00.
//   alarm_ring sets on the tick where the new time == alarm hh:mm:00 while alarm_on=1.
//   It clears on an inc pulse in RUN, alarm_on=0, rst, or 60 ticks after setting.
//  Undefined: 4-state FSM only; no alarm ports, regs or logic.
// TESTING (sim: CLK_HZ=10, DEBOUNCE_CYC=4)
//  rst pulse mid-count -> all digits 0, pm=0, tick_1hz=0 asynchronously; first tick 10 cycles after release
//  preload 23:59:58 via set, run 20 cycles -> 23:59:59 then 00:00:00, pm 1->0
//  set_mode=1, inc x5, sel, inc x61, sel, inc x3, set_mode=0 -> 05:01:03; holds 10 cycles then 05:01:04
//  button glitch 2 cycles wide -> no edit; held 100 cycles -> exactly one increment
//  time 13:07:00, mode12=1 -> digits 01:07:00 pm=1; mode12=0 -> 13:07:00; ena=0 for 50 cycles -> no change
//  RTC_ALARM_EN: alarm 00:01, alarm_on=1, start 00:00:55 -> alarm_ring rises on the 00:01:00 tick, falls 60 ticks later

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24 h BCD time-of-day core with 1 Hz enable, debounced manual-set FSM and 12/24 h display.
// Define RTC_ALARM_EN to add the alarm fields (SET_AH/SET_AM) and the alarm_on/alarm_ring ports.
module rtc_timekeeper #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       CLK_100M,
  input  logic       rst,
  input  logic       ena,
  input  logic       set_mode,
  input  logic       sel_btn,
  input  logic       inc_btn,
  input  logic       mode12,
`ifdef RTC_ALARM_EN
  input  logic       alarm_on,
  output logic       alarm_ring,
`endif
  output logic [1:0] hour_high,
  output logic [3:0] hour_low,
  output logic [2:0] minute_high,
  output logic [3:0] minute_low,
  output logic [2:0] second_high,
  output logic [3:0] second_low,
  output logic       pm,
  output logic       tick_1hz
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
`ifdef RTC_ALARM_EN
  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, SET_AH, SET_AM} state_t;
`else
  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;
`endif
  state_t state, nstate;
  logic [PW-1:0] pre;
  logic [4:0] hr, eh, nh, src_h, dh;
  logic [5:0] mn, sc, em, es, nm, ns, src_m, src_s;
  logic sm1, sm2, sm_d, set_rise, set_fall, tick, sel_p, inc_p;
  logic [1:0] b_s1, b_s2, b_db, b_dd, pulse;
  logic [DW-1:0] b_cnt [2];
  // A button level is accepted only after staying different from the debounced value for DEBOUNCE_CYC cycles
  always_ff @(posedge CLK_100M or posedge rst)
    if (rst) begin
      {sm1, sm2, sm_d} <= '0;
      {b_s1, b_s2, b_db, b_dd} <= '0;
      for (int i = 0; i < 2; i++) b_cnt[i] <= '0;
    end else begin
      {sm1, sm2, sm_d} <= {set_mode, sm1, sm2};
      b_s1 <= {inc_btn, sel_btn};
      b_s2 <= b_s1;
      b_dd <= b_db;
      for (int i = 0; i < 2; i++)
        if (b_s2[i] == b_db[i]) b_cnt[i] <= '0;
        else if (b_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          b_db[i]  <= b_s2[i];
          b_cnt[i] <= '0;
        end else b_cnt[i] <= b_cnt[i] + 1'b1;
    end
  assign pulse    = b_db & ~b_dd;
  assign sel_p    = pulse[0];
  assign inc_p    = pulse[1];
  assign set_rise = sm2 & ~sm_d;
  assign set_fall = ~sm2 & sm_d;
  assign tick     = state == RUN && ena && !set_rise && pre == PW'(CLK_HZ - 1);
  assign tick_1hz = tick;
  assign ns = sc == 6'd59 ? '0 : sc + 6'd1;
  assign nm = sc != 6'd59 ? mn : mn == 6'd59 ? '0 : mn + 6'd1;
  assign nh = (sc != 6'd59 || mn != 6'd59) ? hr : hr == 5'd23 ? '0 : hr + 5'd1;
  always_ff @(posedge CLK_100M or posedge rst)
    if (rst) state <= RUN;
    else state <= nstate;
  always_comb begin
    nstate = state;
    if (state == RUN) nstate = set_rise ? SET_H : RUN;
    else if (set_fall) nstate = RUN;
    else if (sel_p) nstate = state == SET_H ? SET_M : state == SET_M ? SET_S :
`ifdef RTC_ALARM_EN
                             state == SET_S ? SET_AH : state == SET_AH ? SET_AM :
`endif
                             SET_H;
  end
  always_ff @(posedge CLK_100M or posedge rst)
    if (rst) begin
      pre <= '0;
      {hr, mn, sc} <= '0;
      {eh, em, es} <= '0;
    end else begin
      pre <= (state != RUN || set_rise) ? '0 : !ena ? pre : pre == PW'(CLK_HZ - 1) ? '0 : pre + 1'b1;
      if (state == RUN) begin
        if (set_rise) {eh, em, es} <= {hr, mn, sc};
        else if (tick) {hr, mn, sc} <= {nh, nm, ns};
      end else if (set_fall) {hr, mn, sc} <= {eh, em, es};
      else if (inc_p) begin
        if (state == SET_H) eh <= eh == 5'd23 ? '0 : eh + 5'd1;
        if (state == SET_M) em <= em == 6'd59 ? '0 : em + 6'd1;
        if (state == SET_S) es <= es == 6'd59 ? '0 : es + 6'd1;
      end
    end
`ifdef RTC_ALARM_EN
  logic [4:0] ah;
  logic [5:0] am, rcnt;
  logic show_al;
  // Ring for 60 ticks starting on the tick that lands exactly on hh:mm:00 of the alarm
  always_ff @(posedge CLK_100M or posedge rst)
    if (rst) begin
      {ah, am, rcnt} <= '0;
      alarm_ring <= 1'b0;
    end else begin
      if (inc_p && state == SET_AH) ah <= ah == 5'd23 ? '0 : ah + 5'd1;
      if (inc_p && state == SET_AM) am <= am == 6'd59 ? '0 : am + 6'd1;
      if (!alarm_on || (state == RUN && inc_p)) alarm_ring <= 1'b0;
      else if (tick && nh == ah && nm == am && ns == '0) begin
        alarm_ring <= 1'b1;
        rcnt <= '0;
      end else if (tick && alarm_ring) begin
        alarm_ring <= rcnt != 6'd59;
        rcnt <= rcnt + 6'd1;
      end
    end
  assign show_al = state == SET_AH || state == SET_AM;
  assign src_h = show_al ? ah : state == RUN ? hr : eh;
  assign src_m = show_al ? am : state == RUN ? mn : em;
  assign src_s = show_al ? '0 : state == RUN ? sc : es;
`else
  assign src_h = state == RUN ? hr : eh;
  assign src_m = state == RUN ? mn : em;
  assign src_s = state == RUN ? sc : es;
`endif
  assign dh          = !mode12 ? src_h : src_h == '0 ? 5'd12 : src_h > 5'd12 ? src_h - 5'd12 : src_h;
  assign hour_high   = 2'(dh / 5'd10);
  assign hour_low    = 4'(dh % 5'd10);
  assign minute_high = 3'(src_m / 6'd10);
  assign minute_low  = 4'(src_m % 6'd10);
  assign second_high = 3'(src_s / 6'd10);
  assign second_low  = 4'(src_s % 6'd10);
  assign pm          = src_h >= 5'd12;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: randomized and directed checks of rtc_timekeeper against a seconds-of-day model.
module tb_rtc_timekeeper;
  localparam int HZ = 10, DEB = 4;
`ifdef RTC_ALARM_EN
  localparam int NF = 5;
`else
  localparam int NF = 3;
`endif
  logic CLK_100M = 0, rst = 0, ena = 1, set_mode = 0, sel_btn = 0, inc_btn = 0, mode12 = 0;
  logic [1:0] hour_high;
  logic [3:0] hour_low, minute_low, second_low;
  logic [2:0] minute_high, second_high;
  logic pm, tick_1hz;
`ifdef RTC_ALARM_EN
  logic alarm_on = 0, alarm_ring;
`endif
  logic [24:0] got_d;
  int n_vec = 0, n_bad = 0;
  int tod = 0, e_cnt = 0, eh = 0, em = 0, es = 0, f = 0, ah = 0, am = 0;
  bit in_set = 0;

  rtc_timekeeper #(.CLK_HZ(HZ), .DEBOUNCE_CYC(DEB)) dut (
    .CLK_100M(CLK_100M), .rst(rst), .ena(ena), .set_mode(set_mode), .sel_btn(sel_btn),
    .inc_btn(inc_btn), .mode12(mode12),
`ifdef RTC_ALARM_EN
    .alarm_on(alarm_on), .alarm_ring(alarm_ring),
`endif
    .hour_high(hour_high), .hour_low(hour_low), .minute_high(minute_high), .minute_low(minute_low),
    .second_high(second_high), .second_low(second_low), .pm(pm), .tick_1hz(tick_1hz));

  always #5 CLK_100M = ~CLK_100M;
  assign got_d = {pm, 2'b0, hour_high, hour_low, 1'b0, minute_high, minute_low, 1'b0, second_high, second_low};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] disp(int h, int m, int s, bit m12);
    int dh;
    dh = m12 ? (h == 0 ? 12 : (h > 12 ? h - 12 : h)) : h;
    return {(h >= 12), 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Time seen in run = time loaded at run start plus one second per HZ enabled cycles
  function automatic int cur();
    return (tod + e_cnt / HZ) % 86400;
  endfunction

  task automatic check_disp(input string tag);
    logic [24:0] e;
    int t;
    if (in_set) begin
      e = f >= 3 ? disp(ah, am, 0, mode12) : disp(eh, em, es, mode12);
      chk(tag, {8'h0, got_d[23:0]}, {8'h0, e[23:0]});
    end else begin
      t = cur();
      chk(tag, 32'(got_d), 32'(disp(t / 3600, (t / 60) % 60, t % 60, mode12)));
    end
  endtask

  task automatic step();
    bit en;
    en = ena;
    @(posedge CLK_100M);
    #1;
    if (!in_set && en) e_cnt++;
  endtask

  task automatic run(input int n, input bit rnd, input string tag);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        ena = ($urandom % 4) != 0;
        mode12 = $urandom % 2;
      end
      step();
      check_disp(tag);
      chk({tag, "_tick"}, 32'(tick_1hz), (!in_set && ena && e_cnt % HZ == HZ - 1) ? 1 : 0);
    end
  endtask

  task automatic inc_field();
    case (f)
      0: eh = (eh + 1) % 24;
      1: em = (em + 1) % 60;
      2: es = (es + 1) % 60;
      3: ah = (ah + 1) % 24;
      default: am = (am + 1) % 60;
    endcase
  endtask

  task automatic press(input bit s, input bit i, input int hold);
    sel_btn = s;
    inc_btn = i;
    repeat (hold) step();
    sel_btn = 0;
    inc_btn = 0;
    repeat (8) step();
    if (in_set && hold >= DEB + 3) begin
      if (i) inc_field();
      if (s) f = (f + 1) % NF;
    end
  endtask

  task automatic enter_set();
    int t;
    set_mode = 1;
    step();
    step();
    in_set = 1;
    t = cur();
    eh = t / 3600;
    em = (t / 60) % 60;
    es = t % 60;
    f = 0;
    step();
  endtask

  task automatic exit_set();
    set_mode = 0;
    repeat (3) step();
    tod = eh * 3600 + em * 60 + es;
    e_cnt = 0;
    in_set = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    enter_set();
    repeat ((h - eh + 24) % 24) press(0, 1, 8);
    press(1, 0, 8);
    repeat ((m - em + 60) % 60) press(0, 1, 8);
    press(1, 0, 8);
    repeat ((s - es + 60) % 60) press(0, 1, 8);
    check_disp("set_view");
    exit_set();
  endtask

  task automatic model_reset();
    {tod, e_cnt, eh, em, es, f, ah, am} = '0;
    in_set = 0;
  endtask

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_digits", 32'(got_d), 0);
    chk("rst_tick", 32'(tick_1hz), 0);
    mode12 = 1;
    #1 chk("rst_m12", 32'(got_d), 32'(disp(0, 0, 0, 1)));
    mode12 = 0;
    repeat (2) @(posedge CLK_100M);
    #1 rst = 0;
    model_reset();
    run(25, 0, "count");
    #3 rst = 1;
    #1;
    chk("rst_mid_digits", 32'(got_d), 0);
    chk("rst_mid_tick", 32'(tick_1hz), 0);
    @(posedge CLK_100M);
    #1 rst = 0;
    model_reset();
    run(9, 0, "after_rst");
    chk("pre_first_tick", 32'(got_d), 0);
    run(1, 0, "first_tick");
    chk("first_sec", 32'(got_d), 32'(disp(0, 0, 1, 0)));
    set_time(23, 59, 58);
    chk("preload", 32'(got_d), 32'(disp(23, 59, 58, 0)));
    run(20, 0, "rollover");
    chk("rollover_end", 32'(got_d), 32'(disp(0, 0, 0, 0)));
    enter_set();
    repeat (5) press(0, 1, 8);
    press(1, 0, 8);
    repeat (61) press(0, 1, 8);
    press(1, 0, 8);
    repeat (3) press(0, 1, 8);
    exit_set();
    chk("set_result", 32'(got_d), 32'(disp(5, 1, 3, 0)));
    run(9, 0, "set_hold");
    chk("set_hold9", 32'(got_d), 32'(disp(5, 1, 3, 0)));
    run(1, 0, "set_tick");
    chk("set_tick1", 32'(got_d), 32'(disp(5, 1, 4, 0)));
    enter_set();
    press(0, 1, 2);
    check_disp("glitch");
    press(0, 1, 100);
    check_disp("held");
    chk("held_hour", 32'(hour_low), 32'(6));
    press(1, 1, 8);
    check_disp("sel_inc");
    press(0, 1, 8);
    check_disp("min_inc");
    exit_set();
    ena = 0;
    set_time(13, 7, 0);
    mode12 = 1;
    #1 chk("m12_view", 32'(got_d), 32'(disp(13, 7, 0, 1)));
    mode12 = 0;
    #1 chk("m24_view", 32'(got_d), 32'(disp(13, 7, 0, 0)));
    run(50, 0, "frozen");
    chk("frozen_end", 32'(got_d), 32'(disp(13, 7, 0, 0)));
    ena = 1;
    for (int k = 0; k < 8; k++) begin
      set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      run($urandom_range(20, 60), 1, "rand");
    end
    ena = 1;
    mode12 = 0;
`ifdef RTC_ALARM_EN
    enter_set();
    repeat (3) press(1, 0, 8);
    repeat ((24 - ah) % 24) press(0, 1, 8);
    press(1, 0, 8);
    repeat ((61 - am) % 60) press(0, 1, 8);
    check_disp("alarm_view");
    exit_set();
    set_time(0, 0, 55);
    alarm_on = 1;
    for (int i = 0; i < 700; i++) begin
      int d;
      step();
      check_disp("alarm_run");
      d = (cur() - (ah * 3600 + am * 60) + 86400) % 86400;
      chk("alarm_ring", 32'(alarm_ring), d < 60 ? 1 : 0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
